// File: rtl/sudoku_group_ctrl.sv
// Sweep sequencer for one sudoku constraint group: read, mask, broadcast, latch.
// Optional SUDOKU_GROUP_ABORT_ON_CONFLICT_EN ends the sweep at the first conflict.
module sudoku_group_ctrl #(
   parameter  int N_CELLS = 9,
   localparam int IDX_W   = $clog2(N_CELLS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               progress,
   output logic               conflict,
   output logic               all_solved,
   output logic [8:0]         used_mask,
   output logic [N_CELLS-1:0] cell_oe,
   output logic [N_CELLS-1:0] cell_we,
   output logic               cell_address,
   output logic               bus_drive,
   output logic [8:0]         bus_out,
   input  logic [8:0]         bus_in,
   output logic               latch_singleton,
   input  logic [N_CELLS-1:0] is_singleton,
   input  logic [N_CELLS-1:0] solved
);

`ifdef SUDOKU_GROUP_ABORT_ON_CONFLICT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_LATCH,
      S_DONE
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [8:0]       used;
   logic [8:0]       nxt_used;
   logic             bad;

   assign used_mask = used;

   // Classify the value on the bus: malformed or already-used digit is a conflict
   always_comb begin
      nxt_used = used | bus_in;
      bad      = 1'b0;
      if (bus_in != 9'd0) begin
         if ((bus_in & (bus_in - 9'd1)) != 9'd0) bad = 1'b1;
         if ((bus_in & used) != 9'd0) bad = 1'b1;
      end
   end

   // Sweep FSM; every output is registered and set up one state ahead
   always_ff @(posedge clk) begin
      if (!reset) begin
         state           <= S_IDLE;
         idx             <= '0;
         used            <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         progress        <= 1'b0;
         conflict        <= 1'b0;
         all_solved      <= 1'b0;
         cell_oe         <= '0;
         cell_we         <= '0;
         cell_address    <= 1'b0;
         bus_drive       <= 1'b0;
         bus_out         <= '0;
         latch_singleton <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  used       <= '0;
                  conflict   <= 1'b0;
                  progress   <= 1'b0;
                  all_solved <= 1'b0;
                  idx        <= '0;
                  busy       <= 1'b1;
                  cell_oe    <= N_CELLS'(1);
                  state      <= S_READ;
               end
            end
            S_READ: begin
               used <= nxt_used;
               if (bad) conflict <= 1'b1;
               if (bad && ABORT_EN) begin
                  cell_oe <= '0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end else if (idx == IDX_W'(N_CELLS - 1)) begin
                  cell_oe      <= '0;
                  cell_we      <= '1;
                  cell_address <= 1'b1;
                  bus_drive    <= 1'b1;
                  bus_out      <= ~nxt_used;
                  state        <= S_WRITE;
               end else begin
                  idx     <= idx + IDX_W'(1);
                  cell_oe <= cell_oe << 1;
               end
            end
            S_WRITE: begin
               cell_we         <= '0;
               cell_address    <= 1'b0;
               bus_drive       <= 1'b0;
               bus_out         <= '0;
               latch_singleton <= 1'b1;
               state           <= S_LATCH;
            end
            S_LATCH: begin
               latch_singleton <= 1'b0;
               progress        <= |(is_singleton & ~solved);
               all_solved      <= &solved;
               busy            <= 1'b0;
               done            <= 1'b1;
               state           <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sudoku_group_ctrl.sv
// Bench for sudoku_group_ctrl: behavioural cells on the bus plus a group-level model.
// Honours SUDOKU_GROUP_ABORT_ON_CONFLICT_EN when computing expected sweeps.
module tb_sudoku_group_ctrl;
   localparam int N = 9;
`ifdef SUDOKU_GROUP_ABORT_ON_CONFLICT_EN
   localparam bit ABORT = 1'b1;
`else
   localparam bit ABORT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         busy, done, progress, conflict, all_solved;
   logic [8:0]   used_mask;
   logic [N-1:0] cell_oe, cell_we;
   logic         cell_address, bus_drive, latch_singleton;
   logic [8:0]   bus_out, bus_in;
   logic [N-1:0] is_singleton, solved;

   int checks = 0;
   int errors = 0;
   int we_count = 0;
   int latch_count = 0;
   logic [8:0] wr_bus = '0;
   logic prev_done = 1'b0;

   logic [8:0] vals[N];
   logic [8:0] valid[N];
   logic [8:0] load_vals[N];
   logic       load = 1'b0;

   int         exp_lat, exp_we;
   logic [8:0] exp_used, exp_free;
   logic       exp_conf, exp_prog, exp_solv, exp_fill;

   sudoku_group_ctrl #(.N_CELLS(N)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .progress(progress), .conflict(conflict), .all_solved(all_solved),
      .used_mask(used_mask), .cell_oe(cell_oe), .cell_we(cell_we),
      .cell_address(cell_address), .bus_drive(bus_drive), .bus_out(bus_out),
      .bus_in(bus_in), .latch_singleton(latch_singleton),
      .is_singleton(is_singleton), .solved(solved)
   );

   always #5 clk = ~clk;

   // Shared bus and per-cell status flags
   always_comb begin
      bus_in = '0;
      if (bus_drive) bus_in = bus_out;
      for (int i = 0; i < N; i++) begin
         if (cell_oe[i]) bus_in = bus_in | vals[i];
         solved[i] = (vals[i] != 9'd0);
         is_singleton[i] = (vals[i] == 9'd0) && ($countones(valid[i]) == 1);
      end
   end

   // Behavioural cells: valid-mask write and singleton commit
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (load) begin
            vals[i]  <= load_vals[i];
            valid[i] <= '0;
         end else begin
            if (cell_we[i] && cell_address) valid[i] <= bus_out;
            if (latch_singleton && is_singleton[i]) vals[i] <= valid[i];
         end
      end
   end

   // Per-cycle protocol invariants and event counting
   always @(negedge clk) begin
      checks++;
      if ((cell_oe & (cell_oe - 9'd1)) != 9'd0) begin
         errors++;
         $display("FAIL oe_onehot got %b required one-hot or zero", cell_oe);
      end
      checks++;
      if (bus_drive && cell_oe != '0) begin
         errors++;
         $display("FAIL bus_contention drive=%b oe=%b required no overlap", bus_drive, cell_oe);
      end
      checks++;
      if (cell_we != '0 && latch_singleton) begin
         errors++;
         $display("FAIL we_latch_overlap we=%b latch=%b required exclusive", cell_we, latch_singleton);
      end
      checks++;
      if (cell_we != '0 && (cell_we != '1 || !cell_address)) begin
         errors++;
         $display("FAIL we_shape we=%b addr=%b required all-ones with addr 1", cell_we, cell_address);
      end
      checks++;
      if (done && prev_done) begin
         errors++;
         $display("FAIL done_width got done high 2 cycles required 1-cycle pulse");
      end
      if (cell_we != '0) begin
         we_count++;
         wr_bus = bus_out;
      end
      if (latch_singleton) latch_count++;
      prev_done = done;
   end

   task automatic do_load();
      load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
   endtask

   task automatic run_sweep(output int lat, output int nwe, output int nlat);
      int we0, l0;
      we0 = we_count;
      l0 = latch_count;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 1;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1 lat++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL sweep_timeout got no done after %0d cycles", lat);
      end
      nwe = we_count - we0;
      nlat = latch_count - l0;
   endtask

   // Group-level expectation from load_vals: digit set algebra, not FSM steps
   task automatic compute_expect();
      int first;
      logic b, unsolved;
      first = -1;
      exp_conf = 1'b0;
      exp_used = '0;
      unsolved = 1'b0;
      for (int i = 0; i < N; i++) begin
         b = (load_vals[i] != 0) && ($countones(load_vals[i]) != 1);
         for (int j = 0; j < i; j++)
            if ((load_vals[i] & load_vals[j]) != 0) b = 1'b1;
         if (b && first < 0) first = i;
         exp_conf = exp_conf | b;
         exp_used = exp_used | load_vals[i];
         if (load_vals[i] == 0) unsolved = 1'b1;
      end
      exp_free = ~exp_used;
      exp_fill = ($countones(exp_free) == 1);
      exp_prog = unsolved && exp_fill;
      exp_solv = !unsolved;
      exp_lat = N + 3;
      exp_we = 1;
      if (ABORT && first >= 0) begin
         exp_used = '0;
         for (int i = 0; i <= first; i++) exp_used = exp_used | load_vals[i];
         exp_prog = 1'b0;
         exp_solv = 1'b0;
         exp_fill = 1'b0;
         exp_lat = first + 2;
         exp_we = 0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, progress, conflict, all_solved, used_mask, cell_oe, cell_we,
           cell_address, bus_drive, bus_out, latch_singleton} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b used=%h oe=%b we=%b required all 0",
                  busy, used_mask, cell_oe, cell_we);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_empty();
      int lat, nwe, nl;
      for (int i = 0; i < N; i++) load_vals[i] = '0;
      do_load();
      run_sweep(lat, nwe, nl);
      checks++;
      if (lat !== 12) begin errors++; $display("FAIL empty_latency got %0d required 12", lat); end
      checks++;
      if (wr_bus !== 9'h1FF) begin errors++; $display("FAIL empty_bus_out got %h required 1ff", wr_bus); end
      checks++;
      if ({used_mask, progress, conflict} !== 11'd0) begin
         errors++;
         $display("FAIL empty_result got used=%h prog=%b conf=%b required 0/0/0", used_mask, progress, conflict);
      end
   endtask

   task automatic test_one_missing();
      int lat, nwe, nl;
      logic [8:0] one;
      for (int i = 0; i < N; i++) begin
         one = 9'd1;
         load_vals[i] = (i < 8) ? (one << i) : 9'd0;
      end
      do_load();
      run_sweep(lat, nwe, nl);
      checks++;
      if (used_mask !== 9'h0FF) begin errors++; $display("FAIL miss_used got %h required 0ff", used_mask); end
      checks++;
      if (wr_bus !== 9'h100) begin errors++; $display("FAIL miss_bus_out got %h required 100", wr_bus); end
      checks++;
      if ({progress, all_solved} !== 2'b10) begin
         errors++;
         $display("FAIL miss_flags got prog=%b solved=%b required 1/0", progress, all_solved);
      end
      checks++;
      if (vals[8] !== 9'h100) begin errors++; $display("FAIL miss_commit got %h required 100", vals[8]); end
   endtask

   task automatic test_duplicate();
      int lat, nwe, nl;
      for (int i = 0; i < N; i++) load_vals[i] = '0;
      load_vals[2] = 9'h010;
      load_vals[5] = 9'h010;
      do_load();
      run_sweep(lat, nwe, nl);
      checks++;
      if (conflict !== 1'b1) begin errors++; $display("FAIL dup_conflict got %b required 1", conflict); end
      checks++;
      if (lat !== (ABORT ? 7 : 12)) begin
         errors++;
         $display("FAIL dup_latency got %0d required %0d", lat, ABORT ? 7 : 12);
      end
      checks++;
      if (nwe !== (ABORT ? 0 : 1) || nl !== (ABORT ? 0 : 1)) begin
         errors++;
         $display("FAIL dup_we_latch got we=%0d latch=%0d required %0d each", nwe, nl, ABORT ? 0 : 1);
      end
   endtask

   task automatic test_malformed_and_solved();
      int lat, nwe, nl;
      logic [8:0] one;
      for (int i = 0; i < N; i++) load_vals[i] = '0;
      load_vals[3] = 9'h003;
      do_load();
      run_sweep(lat, nwe, nl);
      checks++;
      if ({conflict, used_mask} !== {1'b1, 9'h003}) begin
         errors++;
         $display("FAIL malformed got conf=%b used=%h required 1/003", conflict, used_mask);
      end
      for (int i = 0; i < N; i++) begin
         one = 9'd1;
         load_vals[i] = one << (N - 1 - i);
      end
      do_load();
      run_sweep(lat, nwe, nl);
      checks++;
      if ({all_solved, progress, conflict, used_mask} !== {3'b100, 9'h1FF}) begin
         errors++;
         $display("FAIL solved got solv=%b prog=%b conf=%b used=%h required 1/0/0/1ff",
                  all_solved, progress, conflict, used_mask);
      end
      checks++;
      if (wr_bus !== 9'h000) begin errors++; $display("FAIL solved_bus_out got %h required 000", wr_bus); end
   endtask

   task automatic test_reset_mid();
      int n, we0, l0;
      for (int i = 0; i < N; i++) load_vals[i] = '0;
      do_load();
      we0 = we_count;
      l0 = latch_count;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      while (cell_oe !== 9'h010 && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      checks++;
      if (cell_oe !== 9'h010) begin errors++; $display("FAIL rmid_reach got oe=%b required 010", cell_oe); end
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({busy, done, cell_oe, cell_we, bus_drive, latch_singleton, used_mask} !== '0) begin
         errors++;
         $display("FAIL rmid_outputs got busy=%b oe=%b we=%b required all 0", busy, cell_oe, cell_we);
      end
      reset = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      checks++;
      if (we_count != we0 || latch_count != l0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rmid_quiet got we=%0d latch=%0d busy=%b required 0/0/0",
                  we_count - we0, latch_count - l0, busy);
      end
   endtask

   task automatic test_back_to_back();
      int lat, nwe, nl;
      logic [8:0] held;
      for (int i = 0; i < N; i++) load_vals[i] = (i == 4) ? 9'h020 : 9'h000;
      do_load();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 1;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1 lat++;
         if (lat == 3) start = 1'b1;
         if (lat == 4) start = 1'b0;
      end
      checks++;
      if (lat !== 12) begin errors++; $display("FAIL busy_ignore_latency got %0d required 12", lat); end
      held = used_mask;
      start = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || used_mask !== held) begin
         errors++;
         $display("FAIL start_on_done got busy=%b done=%b used=%h required 0/0/%h", busy, done, used_mask, held);
      end
      run_sweep(lat, nwe, nl);
      checks++;
      if (lat !== 12 || used_mask !== 9'h020) begin
         errors++;
         $display("FAIL back_to_back got lat=%0d used=%h required 12/020", lat, used_mask);
      end
   endtask

   task automatic test_random();
      int lat, nwe, nl, k, t, tmp;
      int perm[N];
      logic [8:0] one, ev;
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < N; i++) perm[i] = i;
         for (int i = N - 1; i > 0; i--) begin
            k = $urandom_range(0, i);
            tmp = perm[i];
            perm[i] = perm[k];
            perm[k] = tmp;
         end
         one = 9'd1;
         for (int i = 0; i < N; i++) begin
            t = $urandom_range(0, 3);
            if (it % 3 == 1) load_vals[i] = (t == 0) ? 9'd0 : (one << $urandom_range(0, 8));
            else load_vals[i] = (t == 0) ? 9'd0 : (one << perm[i]);
         end
         if (it % 6 == 0) begin
            for (int i = 0; i < N; i++) load_vals[i] = one << perm[i];
            load_vals[$urandom_range(0, N - 1)] = 9'd0;
         end
         if (it % 3 == 2) load_vals[$urandom_range(0, N - 1)] = 9'h003 << $urandom_range(0, 7);
         do_load();
         compute_expect();
         run_sweep(lat, nwe, nl);
         checks++;
         if (lat !== exp_lat) begin errors++; $display("FAIL rnd_latency it=%0d got %0d required %0d", it, lat, exp_lat); end
         checks++;
         if ({used_mask, conflict, progress, all_solved} !== {exp_used, exp_conf, exp_prog, exp_solv}) begin
            errors++;
            $display("FAIL rnd_result it=%0d got used=%h c=%b p=%b s=%b required %h/%b/%b/%b", it,
                     used_mask, conflict, progress, all_solved, exp_used, exp_conf, exp_prog, exp_solv);
         end
         checks++;
         if (nwe !== exp_we || nl !== exp_we) begin
            errors++;
            $display("FAIL rnd_we_latch it=%0d got we=%0d latch=%0d required %0d", it, nwe, nl, exp_we);
         end
         if (exp_we == 1) begin
            checks++;
            if (wr_bus !== exp_free) begin
               errors++;
               $display("FAIL rnd_bus_out it=%0d got %h required %h", it, wr_bus, exp_free);
            end
         end
         for (int i = 0; i < N; i++) begin
            ev = (load_vals[i] == 0 && exp_fill) ? exp_free : load_vals[i];
            checks++;
            if (vals[i] !== ev) begin
               errors++;
               $display("FAIL rnd_cell it=%0d cell=%0d got %h required %h", it, i, vals[i], ev);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) load_vals[i] = '0;
      test_reset();
      test_empty();
      test_one_missing();
      test_duplicate();
      test_malformed_and_solved();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
